// File: rtl/pg_fault_ctrl_if.sv
// Request/release handshake and fault broadcast bundle for the mesh power-gating controller.
// NODES must equal MESH_X*MESH_Y of the attached controller.
interface pg_fault_ctrl_if #(
  parameter int NODES = 64
);
  logic             req_valid;
  logic [5:0]       req_node;
  logic             req_ready;
  logic             rel_req;
  logic             net_idle;
  logic             pg_en;
  logic [5:0]       pg_node;
  logic [NODES-1:0] node_clk_en;
  logic             busy;
  logic             err_badnode;

  modport master (
    output req_valid, req_node, rel_req, net_idle,
    input  req_ready, pg_en, pg_node, node_clk_en, busy, err_badnode
  );

  modport slave (
    input  req_valid, req_node, rel_req, net_idle,
    output req_ready, pg_en, pg_node, node_clk_en, busy, err_badnode
  );
endinterface

// File: rtl/pg_fault_ctrl.sv
// Mesh power-gating controller: drains the network, gates one router's clock, broadcasts
// the fault on pg_en/pg_node, and restores the node with a settle period on release.
module pg_fault_ctrl #(
  parameter int MESH_X        = 8,
  parameter int MESH_Y        = 8,
  parameter int DRAIN_CYCLES  = 16,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst,
  pg_fault_ctrl_if.slave bus
);

  localparam int NODES   = MESH_X * MESH_Y;
  localparam int CNT_MAX = (DRAIN_CYCLES > SETTLE_CYCLES) ? DRAIN_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_GATED   = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             pg_en_q;
  logic [5:0]       pg_node_q;
  logic [NODES-1:0] clk_en_q;
  logic             err_q;

  logic             req_bad;
  logic [6:0]       node_idx;
  logic [NODES-1:0] node_sel;

  // 4-bit compare so that a full 8-wide mesh accepts every 3-bit coordinate.
  assign req_bad = ({1'b0, bus.req_node[2:0]} >= 4'(MESH_X)) ||
                   ({1'b0, bus.req_node[5:3]} >= 4'(MESH_Y));

  assign node_idx = 7'(pg_node_q[5:3]) * 7'(MESH_X) + 7'(pg_node_q[2:0]);

  // One-hot mask of the latched node; avoids a variable bit-select on the enable vector.
  generate
    for (genvar gi = 0; gi < NODES; gi++) begin : g_sel
      assign node_sel[gi] = (node_idx == 7'(gi));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pg_en_q   <= 1'b0;
      pg_node_q <= '0;
      clk_en_q  <= '1;
      err_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            if (req_bad) begin
              err_q <= 1'b1;
            end else begin
              pg_node_q <= bus.req_node;
              cnt_q     <= CNT_W'(DRAIN_CYCLES);
              state_q   <= ST_DRAIN;
            end
          end
        end

        ST_DRAIN: begin
          if (bus.rel_req) begin
            state_q <= ST_IDLE;
          end else if (!bus.net_idle) begin
            cnt_q <= CNT_W'(DRAIN_CYCLES);
          end else begin
            if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q <= CNT_W'(1)) begin
              pg_en_q  <= 1'b1;
              clk_en_q <= clk_en_q & ~node_sel;
              state_q  <= ST_GATED;
            end
          end
        end

        ST_GATED: begin
          if (bus.rel_req) begin
            clk_en_q <= clk_en_q | node_sel;
            cnt_q    <= CNT_W'(SETTLE_CYCLES);
            state_q  <= ST_RELEASE;
          end
        end

        ST_RELEASE: begin
          if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q <= CNT_W'(1)) begin
            pg_en_q <= 1'b0;
            state_q <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready   = (state_q == ST_IDLE);
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.pg_en       = pg_en_q;
  assign bus.pg_node     = pg_node_q;
  assign bus.node_clk_en = clk_en_q;
  assign bus.err_badnode = err_q;

endmodule

// File: tb/tb_pg_fault_ctrl.sv
// Directed bench for pg_fault_ctrl: 8x8 instance for gating/release/abort, 4x8 instance for
// out-of-range requests. DRAIN_CYCLES=4, SETTLE_CYCLES=2 on both.
module tb_pg_fault_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   n_asserts = 0;
  int   n_fail    = 0;

  localparam logic [63:0] ALL64   = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] ALL32   = 64'h0000_0000_FFFF_FFFF;
  localparam logic [63:0] GATE43  = 64'hFFFF_F7FF_FFFF_FFFF;
  localparam logic [63:0] GATE0   = 64'hFFFF_FFFF_FFFF_FFFE;

  always #5 clk = ~clk;

  pg_fault_ctrl_if #(.NODES(64)) bus8 ();
  pg_fault_ctrl_if #(.NODES(32)) bus4 ();

  pg_fault_ctrl #(.MESH_X(8), .MESH_Y(8), .DRAIN_CYCLES(4), .SETTLE_CYCLES(2)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  pg_fault_ctrl #(.MESH_X(4), .MESH_Y(8), .DRAIN_CYCLES(4), .SETTLE_CYCLES(2)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
    $display("check %-22s observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  logic [6:0] idle_pat;

  initial begin
    rst            = 1'b1;
    bus8.req_valid = 1'b0;
    bus8.req_node  = '0;
    bus8.rel_req   = 1'b0;
    bus8.net_idle  = 1'b0;
    bus4.req_valid = 1'b0;
    bus4.req_node  = '0;
    bus4.rel_req   = 1'b0;
    bus4.net_idle  = 1'b0;
    idle_pat       = 7'b1111011;

    // Reset values
    tick();
    tick();
    check("rst_pg_en",     64'(bus8.pg_en),       64'd0);
    check("rst_pg_node",   64'(bus8.pg_node),     64'd0);
    check("rst_clk_en",    64'(bus8.node_clk_en), ALL64);
    check("rst_err",       64'(bus8.err_badnode), 64'd0);
    check("rst_busy",      64'(bus8.busy),        64'd0);
    check("rst_req_ready", 64'(bus8.req_ready),   64'd1);
    check("rst_clk_en4",   64'(bus4.node_clk_en), ALL32);
    rst = 1'b0;
    tick();

    // Nominal gating of (3,5)
    bus8.req_valid = 1'b1;
    bus8.req_node  = 6'b101_011;
    bus8.net_idle  = 1'b1;
    tick();
    bus8.req_valid = 1'b0;
    check("nom_busy",      64'(bus8.busy),        64'd1);
    check("nom_req_ready", 64'(bus8.req_ready),   64'd0);
    check("nom_pg_node",   64'(bus8.pg_node),     64'h2B);
    check("nom_pg_en_e0",  64'(bus8.pg_en),       64'd0);
    check("nom_err",       64'(bus8.err_badnode), 64'd0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("nom_pg_en_drain", 64'(bus8.pg_en),       64'd0);
      check("nom_clk_en_drain", 64'(bus8.node_clk_en), ALL64);
    end
    tick();
    check("nom_pg_en_e4",  64'(bus8.pg_en),       64'd1);
    check("nom_clk_en_e4", 64'(bus8.node_clk_en), GATE43);

    // Request while GATED is ignored
    bus8.req_valid = 1'b1;
    bus8.req_node  = 6'b000_000;
    tick();
    check("gated_req_ready", 64'(bus8.req_ready),   64'd0);
    check("gated_pg_node",   64'(bus8.pg_node),     64'h2B);
    check("gated_pg_en",     64'(bus8.pg_en),       64'd1);
    check("gated_clk_en",    64'(bus8.node_clk_en), GATE43);
    bus8.req_valid = 1'b0;

    // Asynchronous reset mid-GATED, observed before any clock edge
    #2;
    rst = 1'b1;
    #1;
    check("arst_bit43",     64'(bus8.node_clk_en[43]), 64'd1);
    check("arst_pg_en",     64'(bus8.pg_en),           64'd0);
    check("arst_req_ready", 64'(bus8.req_ready),       64'd1);
    tick();
    rst = 1'b0;
    tick();

    // Drain restart: net_idle 1,1,0,1,1,1,1 after acceptance
    bus8.req_valid = 1'b1;
    bus8.req_node  = 6'b101_011;
    bus8.net_idle  = 1'b1;
    tick();
    bus8.req_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bus8.net_idle = idle_pat[i];
      tick();
      check($sformatf("restart_pg_en_e%0d", i + 1), 64'(bus8.pg_en), (i == 6) ? 64'd1 : 64'd0);
    end
    check("restart_clk_en", 64'(bus8.node_clk_en), GATE43);

    // Release with settle period
    bus8.rel_req = 1'b1;
    tick();
    bus8.rel_req = 1'b0;
    check("rel_clk_en_r0",    64'(bus8.node_clk_en), ALL64);
    check("rel_pg_en_r0",     64'(bus8.pg_en),       64'd1);
    check("rel_req_ready_r0", 64'(bus8.req_ready),   64'd0);
    tick();
    check("rel_pg_en_r1",     64'(bus8.pg_en),       64'd1);
    tick();
    check("rel_pg_en_r2",     64'(bus8.pg_en),       64'd0);
    check("rel_req_ready_r2", 64'(bus8.req_ready),   64'd1);
    check("rel_busy_r2",      64'(bus8.busy),        64'd0);
    check("rel_pg_node_kept", 64'(bus8.pg_node),     64'h2B);

    // Back-to-back request for (0,0)
    bus8.req_valid = 1'b1;
    bus8.req_node  = 6'b000_000;
    tick();
    bus8.req_valid = 1'b0;
    check("b2b_busy",    64'(bus8.busy),    64'd1);
    check("b2b_pg_node", 64'(bus8.pg_node), 64'h00);
    repeat (4) tick();
    check("b2b_pg_en",   64'(bus8.pg_en),       64'd1);
    check("b2b_clk_en",  64'(bus8.node_clk_en), GATE0);
    bus8.rel_req = 1'b1;
    tick();
    bus8.rel_req = 1'b0;
    repeat (2) tick();
    check("b2b_idle",    64'(bus8.req_ready),   64'd1);
    check("b2b_clk_rst", 64'(bus8.node_clk_en), ALL64);

    // Abort during DRAIN
    bus8.req_valid = 1'b1;
    bus8.req_node  = 6'b101_011;
    tick();
    bus8.req_valid = 1'b0;
    bus8.rel_req   = 1'b1;
    tick();
    bus8.rel_req = 1'b0;
    check("abort_busy",   64'(bus8.busy),        64'd0);
    check("abort_pg_en",  64'(bus8.pg_en),       64'd0);
    check("abort_clk_en", 64'(bus8.node_clk_en), ALL64);
    repeat (5) tick();
    check("abort_pg_en_later", 64'(bus8.pg_en),  64'd0);

    // Abort on the very cycle the drain would complete
    bus8.req_valid = 1'b1;
    tick();
    bus8.req_valid = 1'b0;
    repeat (3) tick();
    check("lastabort_pre_pg_en", 64'(bus8.pg_en), 64'd0);
    bus8.rel_req = 1'b1;
    tick();
    bus8.rel_req = 1'b0;
    check("lastabort_busy",   64'(bus8.busy),        64'd0);
    check("lastabort_pg_en",  64'(bus8.pg_en),       64'd0);
    check("lastabort_clk_en", 64'(bus8.node_clk_en), ALL64);
    tick();
    check("lastabort_pg_en2", 64'(bus8.pg_en),       64'd0);

    // Out-of-range on the 4-column mesh: first latch (2,1) then abort, so pg_node is nonzero
    bus4.req_valid = 1'b1;
    bus4.req_node  = 6'b001_010;
    tick();
    bus4.req_valid = 1'b0;
    bus4.rel_req   = 1'b1;
    tick();
    bus4.rel_req = 1'b0;
    check("oor_setup_pg_node", 64'(bus4.pg_node),   64'h0A);
    check("oor_setup_idle",    64'(bus4.req_ready), 64'd1);
    bus4.req_valid = 1'b1;
    bus4.req_node  = 6'b010_101;
    tick();
    check("oor_err_1",     64'(bus4.err_badnode), 64'd1);
    check("oor_busy",      64'(bus4.busy),        64'd0);
    check("oor_req_ready", 64'(bus4.req_ready),   64'd1);
    check("oor_pg_node",   64'(bus4.pg_node),     64'h0A);
    tick();
    bus4.req_valid = 1'b0;
    check("oor_err_2",     64'(bus4.err_badnode), 64'd1);
    tick();
    check("oor_err_off",   64'(bus4.err_badnode), 64'd0);
    check("oor_pg_en",     64'(bus4.pg_en),       64'd0);
    check("oor_clk_en",    64'(bus4.node_clk_en), ALL32);

    // X=3 is legal on the 4-column mesh
    bus4.req_valid = 1'b1;
    bus4.req_node  = 6'b000_011;
    tick();
    bus4.req_valid = 1'b0;
    check("edge_x3_busy", 64'(bus4.busy),        64'd1);
    check("edge_x3_err",  64'(bus4.err_badnode), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
